// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Define SERSUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Bin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, pd;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             dbit, br_nxt, last;

  always_comb begin
    dbit   = sa[0] ^ sb[0] ^ br;
    br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE:  if (Start) state_nxt = SHIFT;
      SHIFT: begin
        Busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sa   <= '0;
      sb   <= '0;
      pd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
`ifdef SERSUB_OVF_EN
      Ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (Start) begin
          sa  <= A;
          sb  <= B;
          br  <= Bin;
          cnt <= '0;
          pd  <= '0;
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          pd  <= {dbit, pd[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          // Result is committed from the shifted-in value so D is final on this same edge.
          if (last) begin
            D    <= {dbit, pd[WIDTH-1:1]};
            Bout <= br_nxt;
`ifdef SERSUB_OVF_EN
            Ovf  <= br ^ br_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  logic       Clk = 1'b0;
  logic       Rst, Start, Bin;
  logic [7:0] A, B;
  logic       Busy, Done, Bout;
  logic [7:0] D;
`ifdef SERSUB_OVF_EN
  logic       Ovf;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Bin(Bin), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .D(D), .Bout(Bout)
`ifdef SERSUB_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One full operation: accept at edge k, Done in the cycle after edge k+8.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] prev_d, input logic [7:0] exp_d,
                        input logic exp_bout, input logic exp_ovf);
    A = a; B = b; Bin = bin; Start = 1'b1;
    tick();
    Start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
    chk("busy_after_accept", 32'(Busy), 32'd1);
    chk("done_after_accept", 32'(Done), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("busy_shift", 32'(Busy), 32'd1);
      chk("done_shift", 32'(Done), 32'd0);
      chk("d_hold_shift", 32'(D), 32'(prev_d));
    end
    tick();
    chk("done_pulse", 32'(Done), 32'd1);
    chk("busy_done", 32'(Busy), 32'd1);
    chk("d_result", 32'(D), 32'(exp_d));
    chk("bout_result", 32'(Bout), 32'(exp_bout));
`ifdef SERSUB_OVF_EN
    chk("ovf_result", 32'(Ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) chk("ovf_unused", 32'(Done), 32'd1);
`endif
    tick();
    chk("busy_idle", 32'(Busy), 32'd0);
    chk("done_idle", 32'(Done), 32'd0);
    chk("d_hold_idle", 32'(D), 32'(exp_d));
  endtask

  initial begin
    // Reset with a competing Start: no operation may begin.
    Rst = 1'b1; Start = 1'b1; A = 8'hFF; B = 8'h00; Bin = 1'b0;
    tick();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_d", 32'(D), 32'h00);
    chk("rst_bout", 32'(Bout), 32'd0);
    Rst = 1'b0; Start = 1'b0;
    tick();
    chk("rst_no_op", 32'(Busy), 32'd0);

    run_op(8'h5A, 8'h23, 1'b0, 8'h00, 8'h37, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 8'h37, 8'hFF, 1'b1, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Start held high; operands change during SHIFT and must be ignored.
    A = 8'h33; B = 8'h11; Bin = 1'b0; Start = 1'b1;
    tick();                                   // edge k
    A = 8'hAA; B = 8'h55;
    chk("held_busy_k", 32'(Busy), 32'd1);
    repeat (7) tick();                        // edge k+7
    chk("held_no_done_k7", 32'(Done), 32'd0);
    tick();                                   // edge k+8
    chk("held_done_k8", 32'(Done), 32'd1);
    chk("held_d1", 32'(D), 32'h22);
    chk("held_bout1", 32'(Bout), 32'd0);
    tick();                                   // edge k+9
    chk("held_idle_k9", 32'(Busy), 32'd0);
    tick();                                   // edge k+10: second accept
    chk("held_accept_k10", 32'(Busy), 32'd1);
    chk("held_d_hold", 32'(D), 32'h22);
    repeat (7) tick();
    chk("held_no_done_k17", 32'(Done), 32'd0);
    tick();                                   // edge k+18
    chk("held_done_k18", 32'(Done), 32'd1);
    chk("held_d2", 32'(D), 32'h55);
    chk("held_bout2", 32'(Bout), 32'd0);
    Start = 1'b0;
    tick();
    chk("held_end_idle", 32'(Busy), 32'd0);

    // Abort in the 4th SHIFT cycle.
    A = 8'h80; B = 8'h01; Bin = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    chk("abort_busy_pre", 32'(Busy), 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_d", 32'(D), 32'h00);
    chk("abort_bout", 32'(Bout), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_done", 32'(Done), 32'd0);
    end
    run_op(8'h80, 8'h01, 1'b0, 8'h00, 8'h7F, 1'b0, 1'b1);

    run_op(8'h7F, 8'hFF, 1'b0, 8'h7F, 8'h80, 1'b1, 1'b1);
    run_op(8'h05, 8'h03, 1'b0, 8'h80, 8'h02, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing D = A − B − Bin over WIDTH-bit operands, one bit per clock, LSB first, using a single difference/borrow cell and a borrow flip-flop. It is the inverse-operation counterpart to the team's combinational ripple-carry adder: the same operand/carry-style interface (Bin/Bout in place of Cin/Cout), but it trades area for latency behind a Start/Busy/Done handshake. It sits wherever a narrow, low-area subtract is needed and the latency can be tolerated.

## Interface
- WIDTH, 8, operand and result width in bits (≥2); the shift counter is $clog2(WIDTH)+1 bits.
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset; one clock; Rst takes priority over every other input.
- Start  input  1  request; sampled only in IDLE.
- Bin  input  1  borrow-in; captured with the operands.
- A  input  WIDTH  minuend; captured when Start is accepted.
- B  input  WIDTH  subtrahend; captured when Start is accepted.
- Busy  output  1  high in SHIFT and DONE; reset 0.
- Done  output  1  one-cycle pulse marking the result as valid; reset 0.
- D  output  WIDTH  difference, registered; reset 0.
- Bout  output  1  borrow-out (1 iff A < B + Bin, unsigned); reset 0.
- Ovf  output  1  signed overflow; present only with SERSUB_OVF_EN; reset 0.

## Operation
- States: IDLE, SHIFT, DONE. Reset state: IDLE.
- IDLE with Start=1:
  - Load A into the shift register SA and B into SB.
  - Load Bin into the borrow flip-flop br.
  - Clear the count to 0 and the partial-difference register to 0.
  - Go to SHIFT.
- IDLE with Start=0: hold state.
- SHIFT, each cycle:
  - d = SA[0] ^ SB[0] ^ br.
  - br ← (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & br).
  - d shifts into the MSB of the partial-difference register, which shifts right.
  - SA and SB shift right.
  - count increments.
- After the WIDTH-th SHIFT cycle, on the same edge:
  - D ← the completed partial difference.
  - Bout ← the final br.
  - Go to DONE.
- DONE lasts exactly one cycle with Done=1, then returns to IDLE.
- Start outside IDLE (SHIFT or DONE) is ignored. Operands captured at acceptance are not affected by later changes to A, B or Bin.
- D and Bout change only on the completion edge. They hold their value through subsequent IDLE and SHIFT cycles until the next completion or Rst.
- Arithmetic is modulo 2^WIDTH: D = (A − B − Bin) mod 2^WIDTH, and Bout is the unsigned borrow out of the MSB.
- Rst mid-operation aborts the computation:
  - State goes to IDLE.
  - Busy, Done, D, Bout and Ovf go to 0.
  - The partial result is discarded.

## Timing
- Start accepted at edge k → Busy=1 from after edge k.
- Bit i (0 ≤ i < WIDTH) is processed at edge k+1+i.
- D and Bout are valid and Done=1 in the cycle after edge k+WIDTH (k+8 for default WIDTH).
- Edge k+WIDTH+1 → IDLE, Busy=0, Done=0.
- Earliest next acceptance is edge k+WIDTH+2 (Start held high continuously gives one operation every WIDTH+2 cycles).
- Start and Rst in the same cycle: Rst wins; no operation starts.

## Configuration
- SERSUB_OVF_EN defined:
  - Ovf port exists.
  - At the MSB step (count = WIDTH−1) the block records the incoming borrow b_in_msb.
  - On the completion edge, Ovf ← b_in_msb ^ final br, i.e. two's-complement overflow of A − B − Bin.
  - Ovf updates and holds exactly like D and Bout.
- SERSUB_OVF_EN undefined: no Ovf port, no overflow logic; all other behaviour is identical.

## Test plan
- Reset: assert Rst 1 cycle with Start=1, A=0xFF → Busy=0, Done=0, D=0x00, Bout=0; no operation starts.
- A=0x5A, B=0x23, Bin=0, Start at edge k → Done only in the cycle after edge k+8, D=0x37, Bout=0; Busy high for 9 cycles.
- A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1. A=0x10, B=0x0F, Bin=1 → D=0x00, Bout=0.
- Start held high with A/B changed to 0xAA/0x55 during SHIFT → the changes are ignored and the first result completes unaltered. The second operation is accepted at edge k+10 and returns D=0x55, Bout=0.
- Rst asserted at the 4th SHIFT cycle of A=0x80, B=0x01 → next cycle IDLE, D=0x00, Bout=0, Done never pulses. A fresh Start then completes correctly with D=0x7F.
- With SERSUB_OVF_EN:
  - A=0x80, B=0x01 → D=0x7F, Bout=0, Ovf=1.
  - A=0x7F, B=0xFF → D=0x80, Bout=1, Ovf=1.
  - A=0x05, B=0x03 → D=0x02, Ovf=0.
